// File: rtl/product_error_accumulator_pkg.sv
// Shared types and default widths for the product error accumulator.
package product_err_pkg;
  localparam int PROD_W    = 32;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
endpackage

// File: rtl/product_error_accumulator_if.sv
// Sample handshake bus: exact/approx product pair with valid/ready.
interface product_error_accumulator_if
  import product_err_pkg::*;
#(parameter int WIDTH = PROD_W);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] exact;
  logic [WIDTH-1:0] approx;

  modport master (output valid, exact, approx, input ready);
  modport slave  (input valid, exact, approx, output ready);
endinterface

// File: rtl/product_error_accumulator_abs_diff.sv
// Combinational unsigned |a-b| (no wrap) plus inequality flag.
module abs_diff_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag,
  output logic             neq
);
  assign mag = (a >= b) ? a - b : b - a;
  assign neq = (a != b);
endmodule

// File: rtl/product_error_accumulator.sv
// Windowed error-metric accumulator for exact vs approximate products.
// Optional PRODUCT_ERR_SQ_EN adds a sum-of-squared-error output.
module product_error_accumulator
  import product_err_pkg::*;
#(
  parameter int WIDTH   = PROD_W,
  parameter int SAMPLES = 256,
  parameter int ACC_W   = 48
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  product_error_accumulator_if.slave bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ERR_CNT_W-1:0]     err_count_o,
  output logic [ACC_W-1:0]         sum_abs_err_o,
  output logic [WIDTH-1:0]         max_abs_err_o
`ifdef PRODUCT_ERR_SQ_EN
  ,
  output logic [2*WIDTH+15:0]      sum_sq_err_o
`endif
);
  localparam logic [ERR_CNT_W-1:0] LAST = ERR_CNT_W'(SAMPLES - 1);

  state_t               state;
  logic                 ready_q;
  logic [ERR_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     mag, s1_mag;
  logic                 neq, s1_neq, s1_vld;
  logic                 accept, clear;

  assign bus.ready = ready_q;
  assign accept    = bus.valid & ready_q;
  assign clear     = start_i & ((state == IDLE) | (state == DONE));

  abs_diff_unit #(.WIDTH(WIDTH)) u_abs (
    .a   (bus.exact),
    .b   (bus.approx),
    .mag (mag),
    .neq (neq)
  );

  // DRAIN waits for stage 1 to empty so done_o lands two edges after the last accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          state   <= ACCUM;
          ready_q <= 1'b1;
          busy_o  <= 1'b1;
          done_o  <= 1'b0;
          cnt     <= '0;
        end
        ACCUM: if (accept) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: if (!s1_vld) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1_mag <= '0;
      s1_neq <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_mag <= mag;
        s1_neq <= neq;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count_o   <= '0;
      sum_abs_err_o <= '0;
      max_abs_err_o <= '0;
    end else if (clear) begin
      err_count_o   <= '0;
      sum_abs_err_o <= '0;
      max_abs_err_o <= '0;
    end else if (s1_vld) begin
      err_count_o   <= err_count_o + ERR_CNT_W'(s1_neq);
      sum_abs_err_o <= sum_abs_err_o + ACC_W'(s1_mag);
      if (s1_mag > max_abs_err_o) max_abs_err_o <= s1_mag;
    end
  end

`ifdef PRODUCT_ERR_SQ_EN
  logic [2*WIDTH-1:0] sq;
  assign sq = (2*WIDTH)'(s1_mag) * (2*WIDTH)'(s1_mag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       sum_sq_err_o <= '0;
    else if (clear)  sum_sq_err_o <= '0;
    else if (s1_vld) sum_sq_err_o <= sum_sq_err_o + (2*WIDTH+16)'(sq);
  end
`endif
endmodule

// File: tb/tb_product_error_accumulator.sv
// Directed bench for product_error_accumulator (SAMPLES=4); the
// PRODUCT_ERR_SQ_EN build adds a SAMPLES=2 instance for the squared sum.
module tb_product_error_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [15:0] err_count;
  logic [47:0] sum_abs;
  logic [31:0] max_abs;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  product_error_accumulator_if #(.WIDTH(32)) bus ();

`ifdef PRODUCT_ERR_SQ_EN
  logic [79:0] sum_sq_unused;
`endif

  product_error_accumulator #(.WIDTH(32), .SAMPLES(4), .ACC_W(48)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .bus          (bus.slave),
    .busy_o       (busy),
    .done_o       (done),
    .err_count_o  (err_count),
    .sum_abs_err_o(sum_abs),
    .max_abs_err_o(max_abs)
`ifdef PRODUCT_ERR_SQ_EN
    ,
    .sum_sq_err_o (sum_sq_unused)
`endif
  );

`ifdef PRODUCT_ERR_SQ_EN
  logic start2 = 1'b0;
  logic busy2, done2;
  logic [15:0] err_count2;
  logic [47:0] sum_abs2;
  logic [31:0] max_abs2;
  logic [79:0] sum_sq2;
  product_error_accumulator_if #(.WIDTH(32)) bus2 ();
  product_error_accumulator #(.WIDTH(32), .SAMPLES(2), .ACC_W(48)) dut_sq (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start2),
    .bus          (bus2.slave),
    .busy_o       (busy2),
    .done_o       (done2),
    .err_count_o  (err_count2),
    .sum_abs_err_o(sum_abs2),
    .max_abs_err_o(max_abs2),
    .sum_sq_err_o (sum_sq2)
  );
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] e, input logic [31:0] a);
    bus.valid  = v;
    bus.exact  = e;
    bus.approx = a;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0);
`ifdef PRODUCT_ERR_SQ_EN
    bus2.valid = 1'b0; bus2.exact = '0; bus2.approx = '0;
`endif
    #3;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_count", err_count, 16'd0);
    chk("rst_sum",   sum_abs,   48'd0);
    chk("rst_max",   max_abs,   32'd0);
    step();
    rst = 1'b0;

    // IDLE ignores valid
    drive(1'b1, 32'd9, 32'd1);
    step(); step();
    chk("idle_ready", bus.ready, 1'b0);
    chk("idle_sum",   sum_abs,   48'd0);
    chk("idle_busy",  busy,      1'b0);

    // Window 1: exact match
    drive(1'b0, 32'h0, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("w1_ready", bus.ready, 1'b1);
    chk("w1_busy",  busy,      1'b1);
    drive(1'b1, 32'h0000_1234, 32'h0000_1234);
    repeat (4) step();
    chk("w1_ready_drop", bus.ready, 1'b0);
    chk("w1_done_e0",    done,      1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("w1_done_e1", done, 1'b0);
    step();
    chk("w1_done_e2", done,      1'b1);
    chk("w1_busy_e2", busy,      1'b0);
    chk("w1_count",   err_count, 16'd0);
    chk("w1_sum",     sum_abs,   48'd0);
    chk("w1_max",     max_abs,   32'd0);

    // Window 2: mixed errors with gaps
    start = 1'b1; step(); start = 1'b0;
    chk("w2_done_clr", done, 1'b0);
    drive(1'b1, 32'd100, 32'd98);         step();
    drive(1'b0, 32'd50, 32'd0);           step();
    drive(1'b1, 32'd98, 32'd100);         step();
    drive(1'b0, 32'd50, 32'd0);           step();
    drive(1'b1, 32'd5, 32'd5);            step();
    chk("w2_ready_mid", bus.ready, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'h0);    step();
    chk("w2_ready_drop", bus.ready, 1'b0);
    drive(1'b1, 32'd7, 32'd0);
    step();
    chk("w2_done_e1", done, 1'b0);
    step();
    chk("w2_done_e2", done,      1'b1);
    chk("w2_count",   err_count, 16'd3);
    chk("w2_sum",     sum_abs,   48'h1_0000_0003);
    chk("w2_max",     max_abs,   32'hFFFF_FFFF);
    step(); step();
    chk("w2_hold_sum",   sum_abs,   48'h1_0000_0003);
    chk("w2_hold_count", err_count, 16'd3);
    chk("w2_hold_ready", bus.ready, 1'b0);
    chk("w2_hold_done",  done,      1'b1);

    // Restart from DONE clears on the start edge
    start = 1'b1; step(); start = 1'b0;
    chk("w3_clr_count", err_count, 16'd0);
    chk("w3_clr_sum",   sum_abs,   48'd0);
    chk("w3_clr_max",   max_abs,   32'd0);
    chk("w3_clr_done",  done,      1'b0);
    chk("w3_busy",      busy,      1'b1);
    drive(1'b1, 32'd10, 32'd7);
    repeat (4) step();
    drive(1'b0, 32'd0, 32'd0);
    step(); step();
    chk("w3_done",  done,      1'b1);
    chk("w3_count", err_count, 16'd4);
    chk("w3_sum",   sum_abs,   48'd12);
    chk("w3_max",   max_abs,   32'd3);

    // Reset mid-window
    start = 1'b1; step(); start = 1'b0;
    drive(1'b1, 32'd10, 32'd7);
    step(); step();
    chk("w4_partial_sum", sum_abs, 48'd3);
    rst = 1'b1;
    #1;
    chk("w4_rst_ready", bus.ready, 1'b0);
    chk("w4_rst_busy",  busy,      1'b0);
    chk("w4_rst_done",  done,      1'b0);
    chk("w4_rst_count", err_count, 16'd0);
    chk("w4_rst_sum",   sum_abs,   48'd0);
    chk("w4_rst_max",   max_abs,   32'd0);
    rst = 1'b0;
    step(); step();
    chk("w4_idle_ready", bus.ready, 1'b0);
    chk("w4_idle_sum",   sum_abs,   48'd0);
    chk("w4_idle_busy",  busy,      1'b0);
    drive(1'b0, 32'd0, 32'd0);

`ifdef PRODUCT_ERR_SQ_EN
    start2 = 1'b1; step(); start2 = 1'b0;
    bus2.valid = 1'b1; bus2.exact = 32'd10; bus2.approx = 32'd7; step();
    bus2.exact = 32'd4; bus2.approx = 32'd6; step();
    bus2.valid = 1'b0;
    step(); step();
    chk("sq_done", done2,    1'b1);
    chk("sq_sum",  sum_sq2,  80'd13);
    chk("sq_abs",  sum_abs2, 48'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
